// File: rtl/monitor_pkg.sv
// monitor_pkg: shared types and constants for the smoke/current monitor.
// Optional build macro used by the top level: ALARM_BLINK_EN.
package monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_NORMAL   = 2'b01,
    ST_ALERT    = 2'b10,
    ST_SILENCED = 2'b11
  } state_t;

  localparam logic [15:0] DISP_OFF     = 16'h0000;
  localparam logic [15:0] DISP_NORMAL  = 16'h8497;
  localparam logic [15:0] DISP_CURRENT = 16'h1234;
  localparam logic [15:0] DISP_SMOKE   = 16'h5670;

  localparam int unsigned CAUSE_CUR   = 0;
  localparam int unsigned CAUSE_SMOKE = 1;

  // Display word for a given state/cause; smoke takes priority over current.
  function automatic logic [15:0] disp_for(state_t s, logic [1:0] cause);
    logic [15:0] d;
    d = DISP_OFF;
    case (s)
      ST_IDLE:     d = DISP_OFF;
      ST_NORMAL:   d = DISP_NORMAL;
      ST_ALERT,
      ST_SILENCED: d = cause[CAUSE_SMOKE] ? DISP_SMOKE : DISP_CURRENT;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/monitor_sequencer_if.sv
// monitor_sequencer_if: sensor inputs, operator acknowledge and the
// light/alarm/display outputs of the monitor, bundled for port use.
interface monitor_sequencer_if #(
  parameter int unsigned N = 3
);
  logic         humo;
  logic [N-1:0] corriente;
  logic         ack;
  logic         luz_normal;
  logic         luz_alerta;
  logic         alarma;
  logic [3:0]   hexa3;
  logic [3:0]   hexa2;
  logic [3:0]   hexa1;
  logic [3:0]   hexa0;

  modport master (
    output humo, corriente, ack,
    input  luz_normal, luz_alerta, alarma, hexa3, hexa2, hexa1, hexa0
  );

  modport slave (
    input  humo, corriente, ack,
    output luz_normal, luz_alerta, alarma, hexa3, hexa2, hexa1, hexa0
  );
endinterface

// File: rtl/sensor_debounce.sv
// sensor_debounce: counts consecutive true samples of one sensor condition,
// saturating at DEB; o_hit flags the sample that reaches (or holds) DEB.
module sensor_debounce #(
  parameter int unsigned DEB = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sample,
  input  logic       i_cond,
  output logic [3:0] o_count,
  output logic       o_hit
);
  localparam logic [3:0] DEB_C = 4'(DEB);

  logic [3:0] r_count;

  // Consecutive-true counter, cleared on any false sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_sample) begin
      if (!i_cond)               r_count <= '0;
      else if (r_count != DEB_C) r_count <= r_count + 4'd1;
    end
  end

  // Combinational so the cause latches on the same edge as the DEB-th sample.
  assign o_hit   = i_sample && i_cond && (r_count >= DEB_C - 4'd1);
  assign o_count = r_count;

endmodule

// File: rtl/monitor_sequencer.sv
// monitor_sequencer: scan-tick divider, alternating sensor sampling,
// debounced cause latching, ack handling and registered light/display drive.
// Build option: define ALARM_BLINK_EN to make the alarm toggle each tick in ALERT.
module monitor_sequencer
  import monitor_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB      = 4,
  parameter int unsigned I_LIMIT  = 4
) (
  input logic                clk,
  input logic                reset,
  monitor_sequencer_if.slave bus
);
  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [TW-1:0] r_tick_cnt;
  logic          r_phase;
  logic          r_ack_s1, r_ack_s2, r_ack_d;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_cause, w_cause_nxt;
  logic          r_luz_normal, r_luz_alerta, r_alarma;
  logic          w_alarma_nxt;
  logic [15:0]   r_disp;

  logic       w_tick, w_active, w_samp_cur, w_samp_smk;
  logic       w_cur_cond, w_smk_cond, w_ack_rise;
  logic [3:0] w_cnt_cur, w_cnt_smk;
  logic       w_hit_cur, w_hit_smk;
  logic       w_cur_zero_nxt, w_smk_zero_nxt;
  logic [1:0] w_hits, w_new, w_cause_or;

  assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_active   = (r_state != ST_IDLE);
  assign w_samp_cur = w_tick && !r_phase && w_active;
  assign w_samp_smk = w_tick &&  r_phase && w_active;
  assign w_cur_cond = (32'(bus.corriente) >= I_LIMIT);
  assign w_smk_cond = bus.humo;
  assign w_ack_rise = r_ack_s2 && !r_ack_d;

  // Scan tick divider and sensor phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (w_tick) r_phase <= !r_phase;
    end
  end

  // Ack synchronizer plus delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_d  <= 1'b0;
    end else begin
      r_ack_s1 <= bus.ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_d  <= r_ack_s2;
    end
  end

  sensor_debounce #(.DEB(DEB)) u_deb_cur (
    .clk(clk), .reset(reset), .i_sample(w_samp_cur), .i_cond(w_cur_cond),
    .o_count(w_cnt_cur), .o_hit(w_hit_cur)
  );

  sensor_debounce #(.DEB(DEB)) u_deb_smk (
    .clk(clk), .reset(reset), .i_sample(w_samp_smk), .i_cond(w_smk_cond),
    .o_count(w_cnt_smk), .o_hit(w_hit_smk)
  );

  assign w_hits     = {w_hit_smk, w_hit_cur};
  assign w_new      = w_hits & ~r_cause;
  assign w_cause_or = r_cause | w_hits;
  // Counter value after this edge is zero: a false sample clears it now.
  assign w_cur_zero_nxt = w_samp_cur ? !w_cur_cond : (w_cnt_cur == '0);
  assign w_smk_zero_nxt = w_samp_smk ? !w_smk_cond : (w_cnt_smk == '0);

  // Next state, cause and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = w_cause_or;
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_NORMAL;
      ST_NORMAL: if (w_cause_or != '0) w_state_nxt = ST_ALERT;
      ST_ALERT: begin
        // A cause latching together with ack_rise keeps the alarm active.
        if (w_ack_rise && (w_new == '0)) begin
          if ((w_cnt_cur == '0) && (w_cnt_smk == '0)) begin
            w_state_nxt = ST_NORMAL;
            w_cause_nxt = '0;
          end else begin
            w_state_nxt = ST_SILENCED;
          end
        end
      end
      ST_SILENCED: begin
        if (w_new != '0) begin
          w_state_nxt = ST_ALERT;
        end else if (w_tick && w_cur_zero_nxt && w_smk_zero_nxt) begin
          w_state_nxt = ST_NORMAL;
          w_cause_nxt = '0;
        end
      end
    endcase
`ifdef ALARM_BLINK_EN
    w_alarma_nxt = (w_state_nxt == ST_ALERT) &&
                   ((r_state != ST_ALERT) || (w_tick ? !r_alarma : r_alarma));
`else
    w_alarma_nxt = (w_state_nxt == ST_ALERT);
`endif
  end

  // State, cause and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cause      <= '0;
      r_luz_normal <= 1'b0;
      r_luz_alerta <= 1'b0;
      r_alarma     <= 1'b0;
      r_disp       <= DISP_OFF;
    end else begin
      r_state      <= w_state_nxt;
      r_cause      <= w_cause_nxt;
      r_luz_normal <= (w_state_nxt == ST_NORMAL);
      r_luz_alerta <= (w_state_nxt == ST_ALERT) || (w_state_nxt == ST_SILENCED);
      r_alarma     <= w_alarma_nxt;
      r_disp       <= disp_for(w_state_nxt, w_cause_nxt);
    end
  end

  assign bus.luz_normal = r_luz_normal;
  assign bus.luz_alerta = r_luz_alerta;
  assign bus.alarma     = r_alarma;
  assign bus.hexa3      = r_disp[15:12];
  assign bus.hexa2      = r_disp[11:8];
  assign bus.hexa1      = r_disp[7:4];
  assign bus.hexa0      = r_disp[3:0];

endmodule

// File: tb/tb_monitor_sequencer.sv
// tb_monitor_sequencer: directed scenarios plus randomized stimulus, checked
// every cycle against an edge-indexed behavioural model of the monitor.
module tb_monitor_sequencer;
  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned IL = 4;
  localparam int unsigned NW = 3;
  localparam int M_IDLE = 0, M_NORMAL = 1, M_ALERT = 2, M_SIL = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  monitor_sequencer_if #(.N(NW)) bus ();

  monitor_sequencer #(.N(NW), .TICK_DIV(TD), .DEB(DB), .I_LIMIT(IL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: m_e = index of the next clk edge since reset release.
  int       m_e;
  int       m_state;
  bit [1:0] m_cause;
  int       m_cnt [2];
  bit       m_alarm;
  bit       m_hist [3];   // ack as sampled at edges e-1, e-2, e-3

  function automatic void model_reset();
    m_e = 0; m_state = M_IDLE; m_cause = 2'b00; m_alarm = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_hist[0] = 1'b0; m_hist[1] = 1'b0; m_hist[2] = 1'b0;
  endfunction

  function automatic void model_edge();
    bit  rise, tick, cond, old_zero, blink;
    int  sens, prev;
    bit [1:0] hits, newb;
    rise = m_hist[1] && !m_hist[2];
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = bus.ack;
    tick = ((m_e % TD) == TD - 1);
    sens = (m_e / TD) % 2;          // 0: current, 1: smoke
    old_zero = (m_cnt[0] == 0) && (m_cnt[1] == 0);
    hits = 2'b00;
    if (m_state != M_IDLE && tick) begin
      cond = (sens == 1) ? bus.humo : (int'(bus.corriente) >= int'(IL));
      if (cond) begin
        if (m_cnt[sens] < DB) m_cnt[sens]++;
        if (m_cnt[sens] == DB) hits[sens] = 1'b1;
      end else begin
        m_cnt[sens] = 0;
      end
    end
    newb = hits & ~m_cause;
    prev = m_state;
    m_cause = m_cause | hits;
    case (m_state)
      M_IDLE:   m_state = M_NORMAL;
      M_NORMAL: if (m_cause != 0) m_state = M_ALERT;
      M_ALERT:  if (rise && newb == 0) begin
                  if (old_zero) begin m_state = M_NORMAL; m_cause = 0; end
                  else m_state = M_SIL;
                end
      default:  if (newb != 0) m_state = M_ALERT;
                else if (tick && m_cnt[0] == 0 && m_cnt[1] == 0) begin
                  m_state = M_NORMAL; m_cause = 0;
                end
    endcase
`ifdef ALARM_BLINK_EN
    blink = 1'b1;
`else
    blink = 1'b0;
`endif
    if (m_state != M_ALERT)      m_alarm = 1'b0;
    else if (prev != M_ALERT)    m_alarm = 1'b1;
    else if (!blink)             m_alarm = 1'b1;
    else if (tick)               m_alarm = !m_alarm;
    m_e++;
  endfunction

  function automatic logic [2:0] exp_lights();
    return {m_state == M_NORMAL, (m_state == M_ALERT) || (m_state == M_SIL), m_alarm};
  endfunction

  function automatic logic [15:0] exp_disp();
    if (m_state == M_IDLE)   return 16'h0000;
    if (m_state == M_NORMAL) return 16'h8497;
    return m_cause[1] ? 16'h5670 : 16'h1234;
  endfunction

  function automatic logic [2:0] got_lights();
    return {bus.luz_normal, bus.luz_alerta, bus.alarma};
  endfunction

  function automatic logic [15:0] got_disp();
    return {bus.hexa3, bus.hexa2, bus.hexa1, bus.hexa0};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; bus.humo = 1'b0; bus.corriente = '0; bus.ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.humo = 1'b0; bus.corriente = '0; bus.ack = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    if ({got_lights(), got_disp()} !== 19'h0) begin
      bad++; $display("FAIL reset_hold got=%b/%h exp=000/0000", got_lights(), got_disp());
    end
    total++;
    reset = 1'b0;
    #1;
    if ({got_lights(), got_disp()} !== 19'h0) begin
      bad++; $display("FAIL idle_cycle got=%b/%h exp=000/0000", got_lights(), got_disp());
    end
    total++;
    for (int i = 0; i < 200; i++) begin
      step();
      if (got_lights() !== 3'b100 || got_disp() !== 16'h8497) begin
        bad++; $display("FAIL idle_normal e=%0d got=%b/%h exp=100/8497", m_e, got_lights(), got_disp());
      end
      total++;
    end
  endtask

  task automatic test_current();
    bit seen_alarm;
    apply_reset();
    bus.corriente = 3'd5;
    for (int i = 0; i < 30; i++) begin
      step();
      if (got_lights() !== exp_lights() || got_disp() !== exp_disp()) begin
        bad++; $display("FAIL cur5 e=%0d got=%b/%h exp=%b/%h", m_e, got_lights(), got_disp(), exp_lights(), exp_disp());
      end
      total++;
      if (m_e == 19) begin
        if (bus.luz_normal !== 1'b1) begin
          bad++; $display("FAIL cur5_early got=%b exp=1", bus.luz_normal);
        end
        total++;
      end
      if (m_e == 20) begin
        if ({bus.luz_alerta, bus.alarma} !== 2'b11 || got_disp() !== 16'h1234) begin
          bad++; $display("FAIL cur5_alert got=%b%b/%h exp=11/1234", bus.luz_alerta, bus.alarma, got_disp());
        end
        total++;
      end
    end
    apply_reset();
    bus.corriente = 3'd3;
    seen_alarm = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bus.alarma !== 1'b0 || bus.luz_alerta !== 1'b0) seen_alarm = 1'b1;
    end
    if (seen_alarm !== 1'b0) begin
      bad++; $display("FAIL cur3_no_alarm got=1 exp=0");
    end
    total++;
  endtask

  task automatic test_smoke_restart();
    bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      bus.humo = (m_e / 8 < 6) ? pat[m_e / 8] : 1'b1;
      step();
      if (got_lights() !== exp_lights() || got_disp() !== exp_disp()) begin
        bad++; $display("FAIL smoke e=%0d got=%b/%h exp=%b/%h", m_e, got_lights(), got_disp(), exp_lights(), exp_disp());
      end
      total++;
      if (m_e == 47) begin
        if (bus.luz_normal !== 1'b1) begin
          bad++; $display("FAIL smoke_early got=%b exp=1", bus.luz_normal);
        end
        total++;
      end
      if (m_e == 48) begin
        if ({bus.luz_alerta, bus.alarma} !== 2'b11 || got_disp() !== 16'h5670) begin
          bad++; $display("FAIL smoke_alert got=%b%b/%h exp=11/5670", bus.luz_alerta, bus.alarma, got_disp());
        end
        total++;
      end
    end
  endtask

  task automatic test_silence();
    int k, exp_e, seen_e;
    bus.ack = 1'b1; step();
    bus.ack = 1'b0; step(); step();
    if ({bus.luz_normal, bus.luz_alerta, bus.alarma} !== 3'b010 || got_disp() !== 16'h5670) begin
      bad++; $display("FAIL silence got=%b/%h exp=010/5670", got_lights(), got_disp());
    end
    total++;
    bus.humo = 1'b0;
    k = m_e;
    exp_e = k + ((7 - (k % 8)) + 8) % 8;
    seen_e = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (got_lights() !== exp_lights() || got_disp() !== exp_disp()) begin
        bad++; $display("FAIL clear e=%0d got=%b/%h exp=%b/%h", m_e, got_lights(), got_disp(), exp_lights(), exp_disp());
      end
      total++;
      if (seen_e < 0 && bus.luz_normal === 1'b1) seen_e = m_e - 1;
    end
    if (seen_e != exp_e) begin
      bad++; $display("FAIL clear_edge got=%0d exp=%0d", seen_e, exp_e);
    end
    total++;
  endtask

  task automatic test_collision();
    apply_reset();
    bus.humo = 1'b1;
    for (int i = 0; i < 46; i++) begin
      if (m_e == 21) bus.corriente = 3'd5;
      if (m_e == 41) bus.ack = 1'b1;
      if (m_e == 45) bus.ack = 1'b0;
      step();
      if (got_lights() !== exp_lights() || got_disp() !== exp_disp()) begin
        bad++; $display("FAIL collide e=%0d got=%b/%h exp=%b/%h", m_e, got_lights(), got_disp(), exp_lights(), exp_disp());
      end
      total++;
      if (m_e == 44) begin
        if (got_lights() !== 3'b011 || got_disp() !== 16'h5670) begin
          bad++; $display("FAIL collide_alert got=%b/%h exp=011/5670", got_lights(), got_disp());
        end
        total++;
      end
    end
    #2 reset = 1'b1;
    #1;
    if ({got_lights(), got_disp()} !== 19'h0) begin
      bad++; $display("FAIL mid_reset got=%b/%h exp=000/0000", got_lights(), got_disp());
    end
    total++;
    apply_reset();
  endtask

  task automatic test_random();
    int ph, pc;
    apply_reset();
    for (int seg = 0; seg < 15; seg++) begin
      case ($urandom_range(0, 2))
        0: ph = 0;
        1: ph = 40;
        default: ph = 97;
      endcase
      case ($urandom_range(0, 2))
        0: pc = 0;
        1: pc = 50;
        default: pc = 97;
      endcase
      for (int i = 0; i < 200; i++) begin
        bus.humo = ($urandom_range(0, 99) < ph);
        bus.corriente = ($urandom_range(0, 99) < pc) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 4) bus.ack = !bus.ack;
        step();
        if (got_lights() !== exp_lights() || got_disp() !== exp_disp()) begin
          bad++; $display("FAIL random e=%0d got=%b/%h exp=%b/%h", m_e, got_lights(), got_disp(), exp_lights(), exp_disp());
        end
        total++;
      end
    end
  endtask

`ifdef ALARM_BLINK_EN
  task automatic test_blink();
    apply_reset();
    bus.corriente = 3'd5;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_e >= 20) begin
        if (bus.luz_alerta !== 1'b1 || bus.alarma !== 1'(((m_e - 20) / TD) % 2 == 0)) begin
          bad++; $display("FAIL blink e=%0d got=%b%b exp=1%b", m_e, bus.luz_alerta, bus.alarma, 1'(((m_e - 20) / TD) % 2 == 0));
        end
        total++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_current();
    test_smoke_restart();
    test_silence();
    test_collision();
    test_random();
`ifdef ALARM_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
